// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array feed stage.
package systolic_pkg;
  localparam int N         = 4;
  localparam int DW        = 5;
  localparam int DRAIN_CYC = 2*N - 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } feeder_state_t;
endpackage

// File: rtl/skew_delay_line.sv
// DEPTH-stage registered delay for one edge lane; flush zeroes every stage.
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int DW    = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);
  logic [DEPTH-1:0][DW-1:0] r_pipe;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pipe <= '0;
    end else if (flush) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= din;
      for (int k = 1; k < DEPTH; k++) r_pipe[k] <= r_pipe[k-1];
    end
  end

  assign dout = r_pipe[DEPTH-1];
endmodule

// File: rtl/systolic_feeder.sv
// Job sequencer and diagonal skew for the NxN systolic array edges.
// Optional stall counter port enabled by SYSTOLIC_FEEDER_STALLCNT_EN.
module systolic_feeder #(
  parameter int N  = systolic_pkg::N,
  parameter int DW = systolic_pkg::DW,
  parameter int KW = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [KW-1:0]   k_len,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] a_col,
  input  logic [N*DW-1:0] b_row,
  output logic [N*DW-1:0] left_out,
  output logic [N*DW-1:0] top_out,
  output logic            array_clr,
  output logic            busy,
  output logic            done
`ifdef SYSTOLIC_FEEDER_STALLCNT_EN
  ,
  output logic [15:0]     stall_cnt
`endif
);
  import systolic_pkg::*;

  localparam int             DCW     = $clog2(2*N);
  localparam logic [DCW-1:0] L_DRAIN = DCW'(2*N - 1);

  feeder_state_t  r_state, w_next;
  logic [KW-1:0]  r_k_rem;
  logic [DCW-1:0] r_drain;
  logic           r_clr, r_done;
  logic           w_acc, w_flush;

  logic [N-1:0][DW-1:0] w_a_din, w_b_din, w_left, w_top;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (start) w_next = CLEAR;
      CLEAR: w_next = (r_k_rem == '0) ? DONE : LOAD;
      LOAD:  if (w_acc && r_k_rem == KW'(1)) w_next = DRAIN;
      DRAIN: if (r_drain == DCW'(1)) w_next = DONE;
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (r_state == LOAD);
    busy     = (r_state != IDLE);
    w_flush  = (r_state == CLEAR);
    w_acc    = in_ready && in_valid;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_k_rem <= '0;
      r_drain <= '0;
      r_clr   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_clr  <= (r_state == IDLE) && start;
      r_done <= (w_next == DONE);
      if (r_state == IDLE && start)
        r_k_rem <= k_len;
      else if (w_acc && r_k_rem != '0)
        r_k_rem <= r_k_rem - KW'(1);
      if (r_state == LOAD && w_next == DRAIN)
        r_drain <= L_DRAIN;
      else if (r_state == DRAIN)
        r_drain <= r_drain - DCW'(1);
    end
  end

  assign array_clr = r_clr;
  assign done      = r_done;

`ifdef SYSTOLIC_FEEDER_STALLCNT_EN
  logic [15:0] r_stall;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_stall <= '0;
    else if (r_state == CLEAR)
      r_stall <= '0;
    else if (r_state == LOAD && !in_valid && r_stall != 16'hFFFF)
      r_stall <= r_stall + 16'd1;
  end
  assign stall_cnt = r_stall;
`endif

  // Unaccepted cycles feed zeros so bubbles and drain add nothing downstream.
  for (genvar i = 0; i < N; i++) begin : g_lane
    assign w_a_din[i] = w_acc ? a_col[i*DW +: DW] : '0;
    assign w_b_din[i] = w_acc ? b_row[i*DW +: DW] : '0;

    skew_delay_line #(.DEPTH(i+1), .DW(DW)) u_left (
      .clk(clk), .reset_n(reset_n), .flush(w_flush),
      .din(w_a_din[i]), .dout(w_left[i])
    );
    skew_delay_line #(.DEPTH(i+1), .DW(DW)) u_top (
      .clk(clk), .reset_n(reset_n), .flush(w_flush),
      .din(w_b_din[i]), .dout(w_top[i])
    );
  end

  assign left_out = w_left;
  assign top_out  = w_top;
endmodule
